// File: rtl/tcp_rx_port_dispatch.sv
// -----------------------------------------------------------------------------
// tcp_rx_port_dispatch
//
// Routes each received TCP segment to one receive-side demux output. The
// destination-port decapsulator hands over one port per segment. That port is
// looked up in the per-stream port table. The demux enable/select/drop
// controls are then held stable until the segment's last beat is accepted.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_tcp_dest          destination port of the incoming segment
//   i_tcp_dest_valid    one-cycle strobe qualifying i_tcp_dest
//   i_port_table        stream i listen port at [16*i +: 16]
//   i_port_en           stream i takes part in lookup when set
//   i_frame_last        last beat of the routed segment accepted by the demux
//   i_clr_counts        synchronous clear of counters and overflow flag
//   o_enable            demux enable (only in ROUTE)
//   o_select            demux output select
//   o_drop              demux drop (segment consumed, not forwarded)
//   o_busy              a segment is being looked up or routed
//   o_overflow          sticky: a header strobe was lost
//   o_miss_count        saturating count of dropped segments
//   o_hit_count         saturating count of routed segments
//
// Handshake: i_tcp_dest_valid is a strobe with no back-pressure. A port that
// cannot be taken immediately goes to a one-entry pending slot. If that slot
// is already full, the port is lost and o_overflow is set. i_frame_last is
// only meaningful in ROUTE, where it ends the current segment.
// -----------------------------------------------------------------------------
module tcp_rx_port_dispatch #(
  parameter int NUM_TCP   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [15:0]                i_tcp_dest,
  input  logic                       i_tcp_dest_valid,
  input  logic [NUM_TCP*16-1:0]      i_port_table,
  input  logic [NUM_TCP-1:0]         i_port_en,
  input  logic                       i_frame_last,
  input  logic                       i_clr_counts,
  output logic                       o_enable,
  output logic [$clog2(NUM_TCP)-1:0] o_select,
  output logic                       o_drop,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic [CNT_WIDTH-1:0]       o_miss_count,
  output logic [CNT_WIDTH-1:0]       o_hit_count
);

  localparam int SEL_W = $clog2(NUM_TCP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ROUTE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          port_q, port_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [15:0]          pend_port_q, pend_port_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 drop_q, drop_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic                 match_found;
  logic [SEL_W-1:0]     match_idx;
  logic                 ovf_set;
  logic                 hit_inc;
  logic                 miss_inc;

  // Table lookup on the registered port. Scanning from the top down means the
  // lowest matching index is the last assignment and therefore wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_TCP - 1; i >= 0; i--) begin
      if (i_port_en[i] && (i_port_table[16*i +: 16] == port_q) && (port_q != 16'd0)) begin
        match_found = 1'b1;
        match_idx   = i[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    pend_valid_d = pend_valid_q;
    pend_port_d  = pend_port_q;
    sel_d        = sel_q;
    drop_d       = drop_q;
    ovf_set      = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // The older pending port goes first; a simultaneous strobe refills the slot.
          port_d       = pend_port_q;
          pend_valid_d = i_tcp_dest_valid;
          if (i_tcp_dest_valid) pend_port_d = i_tcp_dest;
          state_d      = ST_LOOKUP;
        end else if (i_tcp_dest_valid) begin
          port_d  = i_tcp_dest;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (i_tcp_dest_valid) begin
          if (pend_valid_q) begin
            ovf_set = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_port_d  = i_tcp_dest;
          end
        end
        sel_d    = match_found ? match_idx : '0;
        drop_d   = ~match_found;
        hit_inc  = match_found;
        miss_inc = ~match_found;
        state_d  = ST_ROUTE;
      end

      ST_ROUTE: begin
        if (i_frame_last) begin
          if (pend_valid_q) begin
            // The slot is still full this cycle, so a new strobe is lost.
            port_d       = pend_port_q;
            pend_valid_d = 1'b0;
            ovf_set      = i_tcp_dest_valid;
            state_d      = ST_LOOKUP;
          end else if (i_tcp_dest_valid) begin
            // The strobe would pass through the empty slot; look it up directly.
            port_d  = i_tcp_dest;
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (i_tcp_dest_valid) begin
          if (pend_valid_q) begin
            ovf_set = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_port_d  = i_tcp_dest;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A clear wins over an increment or an overflow in the same cycle.
    if (i_clr_counts) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      hit_cnt_d  = (hit_inc && (hit_cnt_q != '1)) ? hit_cnt_q + CNT_WIDTH'(1) : hit_cnt_q;
      miss_cnt_d = (miss_inc && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_WIDTH'(1) : miss_cnt_q;
      ovf_d      = ovf_q | ovf_set;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      port_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_port_q  <= '0;
      sel_q        <= '0;
      drop_q       <= 1'b0;
      ovf_q        <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      pend_valid_q <= pend_valid_d;
      pend_port_q  <= pend_port_d;
      sel_q        <= sel_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Enable and busy come straight from the state register, so an asynchronous
  // reset removes them without waiting for a clock edge.
  assign o_enable     = (state_q == ST_ROUTE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_select     = sel_q;
  assign o_drop       = drop_q;
  assign o_overflow   = ovf_q;
  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_tcp_rx_port_dispatch.sv
// -----------------------------------------------------------------------------
// tb_tcp_rx_port_dispatch
//
// Self-checking bench for tcp_rx_port_dispatch. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge. The reference model
// works at segment level. Lookup is a first-match search over the table
// arrays. Counters use saturating arithmetic. The overflow flag is sticky.
// -----------------------------------------------------------------------------
module tb_tcp_rx_port_dispatch;

  localparam int NUM_TCP   = 8;
  localparam int CNT_WIDTH = 16;

  // ---------------------------------------------------------------- clock/reset
  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [15:0]           i_tcp_dest;
  logic                  i_tcp_dest_valid;
  logic [NUM_TCP*16-1:0] i_port_table;
  logic [NUM_TCP-1:0]    i_port_en;
  logic                  i_frame_last;
  logic                  i_clr_counts;
  logic                  o_enable;
  logic [2:0]            o_select;
  logic                  o_drop;
  logic                  o_busy;
  logic                  o_overflow;
  logic [CNT_WIDTH-1:0]  o_miss_count;
  logic [CNT_WIDTH-1:0]  o_hit_count;

  always #5 i_clk = ~i_clk;

  tcp_rx_port_dispatch #(.NUM_TCP(NUM_TCP), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_tcp_dest      (i_tcp_dest),
    .i_tcp_dest_valid(i_tcp_dest_valid),
    .i_port_table    (i_port_table),
    .i_port_en       (i_port_en),
    .i_frame_last    (i_frame_last),
    .i_clr_counts    (i_clr_counts),
    .o_enable        (o_enable),
    .o_select        (o_select),
    .o_drop          (o_drop),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow),
    .o_miss_count    (o_miss_count),
    .o_hit_count     (o_hit_count)
  );

  // ---------------------------------------------------------------- model state
  int                   checks = 0;
  int                   errors = 0;
  logic [15:0]          tbl [NUM_TCP];
  logic [NUM_TCP-1:0]   en;
  logic [CNT_WIDTH-1:0] exp_hit;
  logic [CNT_WIDTH-1:0] exp_miss;
  logic                 exp_ovf;
  logic [3:0]           exp_q[$];   // expected {select, drop} per segment

  // A segment goes to the lowest enabled stream whose port equals it.
  // Port 0 never matches.
  function automatic logic [3:0] model_route(input logic [15:0] port);
    logic [3:0] r;
    r = 4'b000_1;
    if (port != 16'd0) begin
      for (int i = 0; i < NUM_TCP; i++) begin
        if (en[i] && tbl[i] == port) begin
          r = {i[2:0], 1'b0};
          break;
        end
      end
    end
    if (r[0]) exp_miss = (exp_miss == 16'hFFFF) ? exp_miss : exp_miss + 16'd1;
    else      exp_hit  = (exp_hit  == 16'hFFFF) ? exp_hit  : exp_hit  + 16'd1;
    return r;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_table();
    for (int i = 0; i < NUM_TCP; i++) i_port_table[16*i +: 16] = tbl[i];
    i_port_en = en;
  endtask

  task automatic set_base_table();
    for (int i = 0; i < NUM_TCP; i++) tbl[i] = 16'd0;
    tbl[0] = 16'd80;
    tbl[3] = 16'd443;
    en     = 8'b0000_1001;
    drive_table();
  endtask

  // Sends one segment starting from IDLE, holds ROUTE for 'hold' extra cycles,
  // then ends it. Spurious frame_last pulses in IDLE/LOOKUP and a scrambled
  // table during ROUTE are applied on the way. Observed values are packed as
  // {en_lookup, busy_lookup, en_route, busy_route, sel, drop, held_ok, en_after, busy_after}.
  task automatic send_segment(input logic [15:0] port, input int hold, output logic [10:0] obs);
    logic en_l, busy_l, en_r, busy_r, drop_r, held_ok, en_a, busy_a;
    logic [2:0] sel_r;
    i_tcp_dest       = port;
    i_tcp_dest_valid = 1'b1;
    i_frame_last     = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    en_l             = o_enable;
    busy_l           = o_busy;
    i_tcp_dest_valid = 1'b0;
    i_tcp_dest       = 16'($urandom);
    i_frame_last     = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    en_r   = o_enable;
    busy_r = o_busy;
    sel_r  = o_select;
    drop_r = o_drop;
    i_frame_last = 1'b0;
    for (int i = 0; i < NUM_TCP; i++) i_port_table[16*i +: 16] = 16'($urandom_range(0, 65535));
    i_port_en = 8'($urandom_range(0, 255));
    held_ok = 1'b1;
    repeat (hold) begin
      @(negedge i_clk);
      if (!(o_enable && o_select == sel_r && o_drop == drop_r)) held_ok = 1'b0;
    end
    i_frame_last = 1'b1;
    @(negedge i_clk);
    i_frame_last = 1'b0;
    drive_table();
    en_a   = o_enable;
    busy_a = o_busy;
    obs = {en_l, busy_l, en_r, busy_r, sel_r, drop_r, held_ok, en_a, busy_a};
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [CNT_WIDTH*2+6:0] got;
    got = {o_enable, o_select, o_drop, o_busy, o_overflow, o_miss_count, o_hit_count};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_hit();
    logic [10:0] obs;
    logic [3:0]  e;
    set_base_table();
    exp_q.push_back(model_route(16'd443));
    send_segment(16'd443, 3, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== {4'b0111, e, 3'b100}) begin
      errors++;
      $display("FAIL hit_443: got %b expected %b", obs, {4'b0111, e, 3'b100});
    end
    checks++;
    if ({o_hit_count, o_miss_count} !== {exp_hit, exp_miss}) begin
      errors++;
      $display("FAIL hit_counts: got %h/%h expected %h/%h", o_hit_count, o_miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_miss();
    logic [10:0] obs;
    logic [3:0]  e;
    logic [15:0] port;
    for (int c = 0; c < 3; c++) begin
      set_base_table();
      case (c)
        0: port = 16'd22;
        1: begin port = 16'd0;  tbl[1] = 16'd0; en[1] = 1'b1; drive_table(); end
        default: begin port = 16'd80; en[0] = 1'b0; drive_table(); end
      endcase
      exp_q.push_back(model_route(port));
      send_segment(port, c, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'b0111, e, 3'b100}) begin
        errors++;
        $display("FAIL miss_case%0d: got %b expected %b", c, obs, {4'b0111, e, 3'b100});
      end
      checks++;
      if ({o_hit_count, o_miss_count} !== {exp_hit, exp_miss}) begin
        errors++;
        $display("FAIL miss_counts%0d: got %h/%h expected %h/%h", c, o_hit_count, o_miss_count, exp_hit, exp_miss);
      end
    end
  endtask

  task automatic test_priority();
    logic [10:0] obs;
    logic [3:0]  e;
    set_base_table();
    tbl[1] = 16'd1000;
    tbl[5] = 16'd1000;
    en     = 8'b0010_0010;
    drive_table();
    exp_q.push_back(model_route(16'd1000));
    send_segment(16'd1000, 1, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== {4'b0111, e, 3'b100} || obs[6:4] !== 3'd1) begin
      errors++;
      $display("FAIL priority_1000: got %b expected %b", obs, {4'b0111, e, 3'b100});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    logic       idle_ok;
    set_base_table();
    exp_q.push_back(model_route(16'd80));
    exp_q.push_back(model_route(16'd443));
    i_tcp_dest = 16'd80; i_tcp_dest_valid = 1'b1;
    @(negedge i_clk);
    i_tcp_dest_valid = 1'b0;
    @(negedge i_clk);                              // ROUTE for A
    e = exp_q.pop_front();
    checks++;
    if ({o_enable, o_select, o_drop} !== {1'b1, e}) begin
      errors++;
      $display("FAIL b2b_route_a: got %b expected %b", {o_enable, o_select, o_drop}, {1'b1, e});
    end
    i_tcp_dest = 16'd443; i_tcp_dest_valid = 1'b1;  // B goes to pending
    @(negedge i_clk);
    i_tcp_dest = 16'd22;                           // C finds pending full
    @(negedge i_clk);
    i_tcp_dest_valid = 1'b0;
    exp_ovf = 1'b1;
    checks++;
    if (o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL b2b_overflow: got %b expected %b", o_overflow, exp_ovf);
    end
    i_frame_last = 1'b1;
    @(negedge i_clk);
    i_frame_last = 1'b0;
    checks++;
    if ({o_busy, o_enable} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_no_gap: got busy/en %b expected 10", {o_busy, o_enable});
    end
    @(negedge i_clk);
    e = exp_q.pop_front();
    checks++;
    if ({o_enable, o_select, o_drop} !== {1'b1, e}) begin
      errors++;
      $display("FAIL b2b_route_b: got %b expected %b", {o_enable, o_select, o_drop}, {1'b1, e});
    end
    i_frame_last = 1'b1;
    @(negedge i_clk);
    i_frame_last = 1'b0;
    idle_ok = 1'b1;
    repeat (6) begin
      if (o_busy !== 1'b0 || o_enable !== 1'b0) idle_ok = 1'b0;
      @(negedge i_clk);
    end
    checks++;
    if (idle_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_c_dropped: got idle_ok %b expected 1", idle_ok);
    end
    checks++;
    if ({o_hit_count, o_miss_count} !== {exp_hit, exp_miss}) begin
      errors++;
      $display("FAIL b2b_counts: got %h/%h expected %h/%h", o_hit_count, o_miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0] e;
    set_base_table();
    exp_q.push_back(model_route(16'd80));
    exp_q.push_back(model_route(16'd443));
    i_tcp_dest = 16'd80; i_tcp_dest_valid = 1'b1;
    @(negedge i_clk);
    i_tcp_dest_valid = 1'b0;
    @(negedge i_clk);
    e = exp_q.pop_front();
    checks++;
    if ({o_enable, o_select, o_drop} !== {1'b1, e}) begin
      errors++;
      $display("FAIL same_route_a: got %b expected %b", {o_enable, o_select, o_drop}, {1'b1, e});
    end
    i_tcp_dest = 16'd443; i_tcp_dest_valid = 1'b1; i_frame_last = 1'b1;
    @(negedge i_clk);
    i_tcp_dest_valid = 1'b0; i_frame_last = 1'b0;
    checks++;
    if ({o_busy, o_enable} !== 2'b10) begin
      errors++;
      $display("FAIL same_lookup: got busy/en %b expected 10", {o_busy, o_enable});
    end
    @(negedge i_clk);
    e = exp_q.pop_front();
    checks++;
    if ({o_enable, o_select, o_drop} !== {1'b1, e}) begin
      errors++;
      $display("FAIL same_route_b: got %b expected %b", {o_enable, o_select, o_drop}, {1'b1, e});
    end
    i_frame_last = 1'b1;
    @(negedge i_clk);
    i_frame_last = 1'b0;
  endtask

  task automatic test_saturation();
    logic [10:0] obs;
    logic [3:0]  e;
    set_base_table();
    force dut.hit_cnt_q = 16'hFFFE;
    @(posedge i_clk);
    #1 release dut.hit_cnt_q;
    @(negedge i_clk);
    exp_hit = 16'hFFFE;
    checks++;
    if (o_hit_count !== exp_hit) begin
      errors++;
      $display("FAIL sat_preload: got %h expected %h", o_hit_count, exp_hit);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model_route(16'd443));
      send_segment(16'd443, 0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'b0111, e, 3'b100} || o_hit_count !== exp_hit) begin
        errors++;
        $display("FAIL sat_hit%0d: got %b cnt %h expected %b cnt %h", k, obs, o_hit_count, {4'b0111, e, 3'b100}, exp_hit);
      end
    end
    checks++;
    if (o_hit_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final: got %h expected ffff", o_hit_count);
    end
  endtask

  task automatic test_clear();
    logic [3:0] e;
    set_base_table();
    checks++;
    if (o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL clr_pre_ovf: got %b expected %b", o_overflow, exp_ovf);
    end
    exp_q.push_back(model_route(16'd443));
    i_tcp_dest = 16'd443; i_tcp_dest_valid = 1'b1;
    @(negedge i_clk);                              // LOOKUP: clear together with the hit
    i_tcp_dest_valid = 1'b0;
    i_clr_counts = 1'b1;
    @(negedge i_clk);
    i_clr_counts = 1'b0;
    exp_hit = '0; exp_miss = '0; exp_ovf = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({o_enable, o_select, o_drop, o_overflow, o_hit_count, o_miss_count} !== {1'b1, e, exp_ovf, exp_hit, exp_miss}) begin
      errors++;
      $display("FAIL clr_with_hit: got en %b sel %0d drop %b ovf %b hit %h miss %h expected sel/drop %b all clear",
               o_enable, o_select, o_drop, o_overflow, o_hit_count, o_miss_count, e);
    end
    i_frame_last = 1'b1;
    @(negedge i_clk);
    i_frame_last = 1'b0;
  endtask

  task automatic test_random();
    logic [10:0] obs;
    logic [3:0]  e;
    logic [15:0] port;
    int          hold;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NUM_TCP; i++) tbl[i] = 16'($urandom_range(0, 6));
      en = 8'($urandom_range(0, 255));
      drive_table();
      port = 16'($urandom_range(0, 7));
      hold = $urandom_range(0, 4);
      exp_q.push_back(model_route(port));
      send_segment(port, hold, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'b0111, e, 3'b100}) begin
        errors++;
        $display("FAIL rand%0d_port%0d: got %b expected %b", n, port, obs, {4'b0111, e, 3'b100});
      end
      checks++;
      if ({o_hit_count, o_miss_count} !== {exp_hit, exp_miss}) begin
        errors++;
        $display("FAIL rand%0d_counts: got %h/%h expected %h/%h", n, o_hit_count, o_miss_count, exp_hit, exp_miss);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] obs;
    logic [3:0]  e;
    logic        idle_ok;
    set_base_table();
    void'(model_route(16'd443));
    i_tcp_dest = 16'd443; i_tcp_dest_valid = 1'b1;
    @(negedge i_clk);
    i_tcp_dest_valid = 1'b0;
    @(negedge i_clk);                              // ROUTE
    i_tcp_dest = 16'd80; i_tcp_dest_valid = 1'b1;  // fill pending
    @(negedge i_clk);
    i_tcp_dest_valid = 1'b0;
    checks++;
    if ({o_enable, o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre: got en/busy %b expected 11", {o_enable, o_busy});
    end
    #2 i_rst_n = 1'b0;
    #1;
    exp_hit = '0; exp_miss = '0; exp_ovf = 1'b0;
    checks++;
    if ({o_enable, o_busy, o_overflow, o_hit_count, o_miss_count} !== {2'b00, exp_ovf, exp_hit, exp_miss}) begin
      errors++;
      $display("FAIL arst_no_edge: got en %b busy %b ovf %b hit %h miss %h expected all 0",
               o_enable, o_busy, o_overflow, o_hit_count, o_miss_count);
    end
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    idle_ok = 1'b1;
    repeat (8) begin
      if (o_busy !== 1'b0 || o_enable !== 1'b0) idle_ok = 1'b0;
      @(negedge i_clk);
    end
    checks++;
    if (idle_ok !== 1'b1) begin
      errors++;
      $display("FAIL arst_pending_cleared: got idle_ok %b expected 1", idle_ok);
    end
    exp_q.push_back(model_route(16'd80));
    send_segment(16'd80, 2, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== {4'b0111, e, 3'b100} || o_hit_count !== exp_hit) begin
      errors++;
      $display("FAIL arst_after: got %b hit %h expected %b hit %h", obs, o_hit_count, {4'b0111, e, 3'b100}, exp_hit);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    i_rst_n          = 1'b0;
    i_tcp_dest       = '0;
    i_tcp_dest_valid = 1'b0;
    i_frame_last     = 1'b0;
    i_clr_counts     = 1'b0;
    exp_hit          = '0;
    exp_miss         = '0;
    exp_ovf          = 1'b0;
    set_base_table();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    test_reset();
    test_hit();
    test_miss();
    test_priority();
    test_back_to_back();
    test_same_cycle();
    test_saturation();
    test_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
